// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
//   state_t      : seconds-timebase sequencer states
//   DEF_*_DIV    : default divisors for a 100 MHz master clock
//   max_int()    : helper used to size the seconds counter
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam int DEF_PIX_DIV   = 4;
    localparam int DEF_SCAN_DIV  = 1024;
    localparam int DEF_BLINK_DIV = 1048576;
    localparam int DEF_SEC_DIV   = 100000000;
    localparam int DEF_ADJ_DIV   = 25000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divisor counter producing a registered one-cycle tick.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the counter this cycle
//   clr      : zero the counter, suppress the tick (wins over en)
//   div      : runtime divisor (period in enabled cycles), >= 2
//   tick     : high for the cycle after the edge on which the counter wraps
module tick_gen #(
    parameter int WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           clr,
    input  logic [WIDTH:0] div,
    output logic           tick
);

    logic [WIDTH-1:0] count;
    logic             at_end;

    // div is one bit wider than the counter so a power-of-two divisor fits.
    assign at_end = ({1'b0, count} == (div - (WIDTH+1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (at_end) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Central clock-enable scheduler: free-running pixel/scan strobes, a blink
// level, and a seconds strobe sequenced through IDLE/RUN/PAUSE/STEP.
//   clk, rst   : master clock, asynchronous active-high reset
//   start      : pulse, start/resume seconds timebase
//   pause      : pulse, freeze seconds timebase
//   step       : pulse, one seconds strobe while paused
//   clear      : pulse, back to IDLE with the seconds counter zeroed
//   adjust     : level, use ADJ_DIV instead of SEC_DIV
//   pix_en     : strobe every PIX_DIV cycles
//   scan_en    : strobe every SCAN_DIV cycles
//   blink      : square wave, period 2*BLINK_DIV
//   sec_en     : seconds strobe
//   running    : high in RUN
//   dbg_state  : current sequencer state (state_t encoding)
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PIX_DIV   = DEF_PIX_DIV,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int BLINK_DIV = DEF_BLINK_DIV,
    parameter int SEC_DIV   = DEF_SEC_DIV,
    parameter int ADJ_DIV   = DEF_ADJ_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       step,
    input  logic       clear,
    input  logic       adjust,
    output logic       pix_en,
    output logic       scan_en,
    output logic       blink,
    output logic       sec_en,
    output logic       running,
    output logic [1:0] dbg_state
);

    localparam int PIX_W   = $clog2(PIX_DIV);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int SEC_W   = $clog2(max_int(SEC_DIV, ADJ_DIV));

    localparam logic [PIX_W:0]   PIX_V   = PIX_DIV[PIX_W:0];
    localparam logic [SCAN_W:0]  SCAN_V  = SCAN_DIV[SCAN_W:0];
    localparam logic [BLINK_W:0] BLINK_V = BLINK_DIV[BLINK_W:0];
    localparam logic [SEC_W:0]   SEC_V   = SEC_DIV[SEC_W:0];
    localparam logic [SEC_W:0]   ADJ_V   = ADJ_DIV[SEC_W:0];

    state_t         state;
    logic           adj_q;
    logic           step_strobe;
    logic           blink_q;
    logic           blink_tick;
    logic           sec_tick;
    logic           sec_run;
    logic           sec_clr;
    logic [SEC_W:0] sec_div;

    // ---------------- free-running generators ----------------
    tick_gen #(.WIDTH(PIX_W)) u_pix (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .div(PIX_V), .tick(pix_en)
    );

    tick_gen #(.WIDTH(SCAN_W)) u_scan (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .div(SCAN_V), .tick(scan_en)
    );

    tick_gen #(.WIDTH(BLINK_W)) u_blink (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .div(BLINK_V), .tick(blink_tick)
    );

    // blink_q flips one edge after the wrap; XOR with the tick makes the
    // visible level change in the same cycle the wrap strobe appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else if (blink_tick) begin
            blink_q <= ~blink_q;
        end
    end

    assign blink = blink_q ^ blink_tick;

    // ---------------- seconds timebase ----------------
    // pause on the wrap edge holds the counter at DIV-1, so the first RUN
    // edge after resume wraps and strobes. A rate change restarts the period.
    assign sec_run = (state == RUN) && !pause;
    assign sec_clr = clear || (state == IDLE) || (adjust != adj_q);
    assign sec_div = adjust ? ADJ_V : SEC_V;

    tick_gen #(.WIDTH(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .en(sec_run), .clr(sec_clr), .div(sec_div), .tick(sec_tick)
    );

    assign sec_en    = sec_tick | step_strobe;
    assign dbg_state = state;

    // Sequencer: clear > start > pause > step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            running     <= 1'b0;
            step_strobe <= 1'b0;
            adj_q       <= 1'b0;
        end else begin
            adj_q       <= adjust;
            step_strobe <= (state == STEP) && !clear;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (step) begin
                            state <= STEP;
                        end
                    end
                    STEP: begin
                        state <= PAUSE;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with small divisors.
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int PIX   = 4;
    localparam int SCAN  = 8;
    localparam int BLINK = 16;
    localparam int SEC   = 20;
    localparam int ADJ   = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic       adjust = 1'b0;
    logic       pix_en;
    logic       scan_en;
    logic       blink;
    logic       sec_en;
    logic       running;
    logic [1:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;

    tick_scheduler #(
        .PIX_DIV(PIX), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .SEC_DIV(SEC), .ADJ_DIV(ADJ)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .step(step),
        .clear(clear), .adjust(adjust), .pix_en(pix_en), .scan_en(scan_en),
        .blink(blink), .sec_en(sec_en), .running(running), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // n: edges since reset release. m: mode. p: enabled cycles elapsed in
    // the current seconds period. e_sec: expected seconds strobe.
    int     n;
    state_t m;
    int     p;
    logic   adj_prev;
    logic   e_sec;

    task automatic model_reset();
        n = 0;
        m = IDLE;
        p = 0;
        adj_prev = 1'b0;
        e_sec = 1'b0;
    endtask

    task automatic model_edge();
        logic chg;
        int   dv;
        n++;
        chg = (adjust != adj_prev);
        adj_prev = adjust;
        dv = adjust ? ADJ : SEC;
        e_sec = 1'b0;
        if (clear) begin
            m = IDLE;
            p = 0;
        end else begin
            case (m)
                IDLE: begin
                    p = 0;
                    if (start) m = RUN;
                end
                RUN: begin
                    if (pause) begin
                        m = PAUSE;
                    end else begin
                        p++;
                        if (p == dv) begin
                            p = 0;
                            e_sec = !chg;
                        end
                    end
                end
                PAUSE: begin
                    if (start) m = RUN;
                    else if (step) m = STEP;
                end
                default: begin
                    e_sec = 1'b1;
                    m = PAUSE;
                end
            endcase
        end
        if (chg) p = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pix_en",  {1'b0, pix_en},  {1'b0, (n != 0) && (n % PIX == 0)});
        chk("scan_en", {1'b0, scan_en}, {1'b0, (n != 0) && (n % SCAN == 0)});
        chk("blink",   {1'b0, blink},   {1'b0, ((n / BLINK) % 2) == 1});
        chk("sec_en",  {1'b0, sec_en},  {1'b0, e_sec});
        chk("running", {1'b0, running}, {1'b0, m == RUN});
        chk("state",   dbg_state,       m);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic s, input logic pa, input logic st, input logic cl);
        start = s;
        pause = pa;
        step  = st;
        clear = cl;
        @(posedge clk);
        model_edge();
        #1;
        start = 1'b0;
        pause = 1'b0;
        step  = 1'b0;
        clear = 1'b0;
        check_all();
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_phase(input int target);
        for (int i = 0; i < 100 && p != target; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        if (p != target) begin
            miscompares++;
            $error("FAIL phase_wait: observed=%0d expected=%0d", p, target);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #2;
        check_all();                      // reset values
        @(negedge clk);
        rst = 1'b0;

        // free-running generators only
        idle_cycles(64);

        // start, three seconds periods
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(60);

        // pause on the wrap edge, resume 10 cycles later
        run_until_phase(SEC - 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(9);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(45);

        // single steps while paused
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            idle_cycles(4);
        end
        // step outside PAUSE is ignored
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // rate switch mid-period and back
        run_until_phase(12);
        adjust = 1'b1;
        idle_cycles(16);
        adjust = 1'b0;
        idle_cycles(45);

        // asynchronous reset mid-period
        idle_cycles(7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);

        // clear beats start
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);

        // randomized control traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) adjust = ~adjust;
            cycle($urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Central clock-enable scheduler for the 100 MHz master clock domain. Generates single-cycle enable strobes for the pixel, display-scan and seconds logic, plus a 50%-duty blink level, so all downstream logic runs on `clk` with enables instead of divided clocks. Sequences the seconds timebase through idle/run/pause/single-step modes, with a fast adjust rate, under control of the debounced user inputs.

## Interface
- `PIX_DIV`, 4: pixel strobe period in `clk` cycles (25 MHz).
- `SCAN_DIV`, 1024: display-scan strobe period.
- `BLINK_DIV`, 1048576: blink half-period (level toggles every BLINK_DIV cycles).
- `SEC_DIV`, 100000000: seconds strobe period in normal mode.
- `ADJ_DIV`, 25000000: seconds strobe period while `adjust`=1.
- All divisors ≥ 2; counter widths are `$clog2` of the divisor (seconds counter sized for max(SEC_DIV, ADJ_DIV)).

Ports:
- `clk` in 1: 100 MHz master clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; start/resume seconds timebase.
- `pause` in 1: one-cycle pulse; freeze seconds timebase.
- `step` in 1: one-cycle pulse; emit one seconds strobe while paused.
- `clear` in 1: one-cycle pulse; return to IDLE, zero seconds counter.
- `adjust` in 1: level; select ADJ_DIV instead of SEC_DIV.
- `pix_en` out 1: one-cycle strobe every PIX_DIV cycles.
- `scan_en` out 1: one-cycle strobe every SCAN_DIV cycles.
- `blink` out 1: square wave, period 2·BLINK_DIV.
- `sec_en` out 1: one-cycle seconds strobe.
- `running` out 1: high in RUN.

## Operation
- Free-running generators (pix, scan, blink) start at reset release, independent of the FSM.
- Each generator: counter 0..DIV-1, wraps to 0; strobe registered, high for the cycle after the edge on which the counter wraps. Exact period DIV; never two strobes closer than DIV.
- `blink` toggles on each blink wrap.
- FSM states: IDLE, RUN, PAUSE, STEP.
  - IDLE: seconds counter held at 0. `start` → RUN.
  - RUN: counter advances; wrap at active divisor − 1 → `sec_en`. `pause` → PAUSE.
  - PAUSE: counter holds value. `start` → RUN (resume, count kept). `step` → STEP.
  - STEP: `sec_en` high this cycle, counter unchanged; unconditionally → PAUSE.
- Priority, highest first: `clear` (any state → IDLE, counter 0, no strobe), then `start`, then `pause`, then `step`. `step` outside PAUSE ignored; `start` in RUN ignored; `pause` in IDLE/PAUSE ignored.
- `adjust` change (edge vs registered copy) zeroes the seconds counter that cycle, so no shortened or stretched first period after a rate switch; state unaffected.
- `pause` on the edge where the counter would wrap: pause wins, no strobe, counter holds at DIV-1; first RUN edge after resume wraps and strobes.
- `running` = (state == RUN), registered.

## Timing
- Reset values: all counters 0, state IDLE, `pix_en`=`scan_en`=`sec_en`=0, `blink`=0, `running`=0.
- First `pix_en` high in cycle PIX_DIV after reset release (edges 1..PIX_DIV count 0→wrap); same rule for scan/blink.
- Control inputs sampled on `clk`; state changes one edge after the input pulse; `running` follows state same edge.
- From `start` in IDLE: first `sec_en` exactly DIV cycles after the RUN edge.
- `step`: `sec_en` high in the cycle following the edge after `step` was sampled (two edges from pulse).
- Reset mid-operation: all outputs drop asynchronously to reset values; no partial strobe.

## Structure
- Package `tick_sched_pkg`: state enum (IDLE, RUN, PAUSE, STEP), default divisor constants.
- Sub-module `tick_gen`: divisor counter with `en`, `clr`, runtime `div` input and registered one-cycle `tick`; instantiated for pix, scan, blink, seconds (seconds driven by FSM `en`/`clr` and muxed divisor).

## Test plan
Bench params: PIX_DIV=4, SCAN_DIV=8, BLINK_DIV=16, SEC_DIV=20, ADJ_DIV=5.
- Reset release, run 64 cycles → `pix_en` at cycles 4,8,…; `scan_en` at 8,16,…; `blink` rises at 16, falls at 32; `sec_en` never; `running`=0.
- `start`, run 60 cycles → `running`=1, `sec_en` at 20, 40, 60 cycles after RUN edge.
- RUN, `pause` at count 19 → no strobe, count holds 19; `start` 10 cycles later → `sec_en` on first RUN edge, then every 20.
- PAUSE, `step` ×3 spaced 5 cycles → exactly 3 single-cycle `sec_en`, counter unchanged, state back to PAUSE.
- RUN at count 12, raise `adjust` → counter zeroed, next `sec_en` 5 cycles later, then every 5; drop `adjust` → next after 20.
- RUN, assert `rst` mid-period for 1 cycle → all outputs 0 immediately, state IDLE; `clear`+`start` same cycle → stays IDLE.
